// File: rtl/tank_bullet_if.sv
// ---------------------------------------------------------------------------
// tank_bullet_if
// Signal bundle between the tank mover / VGA side and the tank_bullet
// projectile controller.
//
// Handshake: fire_req is a level request sampled every Clk cycle. The bullet
// block accepts it only in IDLE with a valid tank_dir and answers with a
// single-cycle 'fired' pulse the cycle after acceptance. There is no
// backpressure and no queueing: a request that is not accepted is dropped,
// and a request held high is accepted again as soon as the block re-arms.
//
// Inputs to the bullet block (driven by the master):
//   frame_clk   ~60 Hz frame strobe, asynchronous level
//   fire_req    level request to fire
//   tank_X/Y    tank top-left position (10 bits each)
//   tank_dir    1=up, 2=right, 3=left, 4=down, others invalid
//   hit         external collision, retires the bullet
//   DrawX/Y     current VGA pixel (10 bits each)
// Outputs from the bullet block:
//   bullet_X/Y     bullet top-left position
//   bullet_dir     latched direction
//   bullet_active  bullet in flight
//   fired          one-cycle pulse on spawn
//   is_bullet      current pixel lies inside the bullet
//   dbg_state      FSM state (0=IDLE, 1=FLIGHT, 2=COOLDOWN)
// ---------------------------------------------------------------------------
interface tank_bullet_if;
    logic       frame_clk;
    logic       fire_req;
    logic [9:0] tank_X;
    logic [9:0] tank_Y;
    logic [2:0] tank_dir;
    logic       hit;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic [9:0] bullet_X;
    logic [9:0] bullet_Y;
    logic [2:0] bullet_dir;
    logic       bullet_active;
    logic       fired;
    logic       is_bullet;
    logic [1:0] dbg_state;

    modport master (
        output frame_clk, fire_req, tank_X, tank_Y, tank_dir, hit, DrawX, DrawY,
        input  bullet_X, bullet_Y, bullet_dir, bullet_active, fired, is_bullet,
               dbg_state
    );

    modport slave (
        input  frame_clk, fire_req, tank_X, tank_Y, tank_dir, hit, DrawX, DrawY,
        output bullet_X, bullet_Y, bullet_dir, bullet_active, fired, is_bullet,
               dbg_state
    );
endinterface

// File: rtl/tank_bullet.sv
// ---------------------------------------------------------------------------
// tank_bullet
// Projectile controller for one tank. Spawns a bullet centred on the tank
// when fire is requested, advances it SPEED pixels per frame tick in the
// latched direction, retires it on a screen edge or an external hit, then
// waits COOLDOWN_FRAMES frame ticks before accepting another request.
//
// Ports:
//   Clk    system clock
//   Reset  synchronous, active-high
//   bus    tank_bullet_if.slave (see the interface file for the signal list)
// ---------------------------------------------------------------------------
module tank_bullet #(
    parameter int X_MAX           = 639,
    parameter int Y_MAX           = 479,
    parameter int TANK_SIZE       = 32,
    parameter int BULLET_SIZE     = 4,
    parameter int SPEED           = 4,
    parameter int COOLDOWN_FRAMES = 30
) (
    input  logic         Clk,
    input  logic         Reset,
    tank_bullet_if.slave bus
);

    localparam int CNT_W = $clog2(COOLDOWN_FRAMES + 1);

    localparam logic [9:0]       SPAWN_OFS = 10'((TANK_SIZE - BULLET_SIZE) / 2);
    localparam logic [9:0]       SPEED_10  = 10'(SPEED);
    // Expiry and hit-box arithmetic is done in 11 bits so that sums near the
    // right/bottom edge cannot wrap around a 10-bit coordinate.
    localparam logic [10:0]      SPEED_11  = 11'(SPEED);
    localparam logic [10:0]      X_LIMIT   = 11'(X_MAX + 1 - BULLET_SIZE);
    localparam logic [10:0]      Y_LIMIT   = 11'(Y_MAX + 1 - BULLET_SIZE);
    localparam logic [10:0]      BOX_SPAN  = 11'(BULLET_SIZE - 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(COOLDOWN_FRAMES - 1);

    localparam logic [2:0] DIR_UP    = 3'd1;
    localparam logic [2:0] DIR_RIGHT = 3'd2;
    localparam logic [2:0] DIR_LEFT  = 3'd3;
    localparam logic [2:0] DIR_DOWN  = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_FLIGHT   = 2'd1,
        S_COOLDOWN = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic             r_frame_clk_d;
    logic             r_frame_tick;

    logic [9:0]       r_bullet_x;
    logic [9:0]       r_bullet_y;
    logic [2:0]       r_bullet_dir;
    logic             r_active;
    logic             r_fired;
    logic [CNT_W-1:0] r_cnt;

    logic [9:0]       w_bullet_x_nxt;
    logic [9:0]       w_bullet_y_nxt;
    logic [2:0]       w_bullet_dir_nxt;
    logic             w_active_nxt;
    logic             w_fired_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic             w_dir_valid;
    logic             w_fire_ok;
    logic             w_expired;
    logic             w_cnt_done;
    logic [10:0]      w_bx11;
    logic [10:0]      w_by11;
    logic [10:0]      w_dx11;
    logic [10:0]      w_dy11;

    assign w_dir_valid = (bus.tank_dir >= DIR_UP) && (bus.tank_dir <= DIR_DOWN);
    assign w_fire_ok   = bus.fire_req && w_dir_valid;
    assign w_cnt_done  = (r_cnt == CNT_LAST);

    assign w_bx11 = {1'b0, r_bullet_x};
    assign w_by11 = {1'b0, r_bullet_y};
    assign w_dx11 = {1'b0, bus.DrawX};
    assign w_dy11 = {1'b0, bus.DrawY};

    // A further SPEED step would leave the visible area in the travel
    // direction. The latched direction is always valid in FLIGHT; the
    // default retires the bullet rather than letting it sit forever.
    always_comb begin
        w_expired = 1'b1;
        case (r_bullet_dir)
            DIR_UP:    w_expired = (w_by11 < SPEED_11);
            DIR_DOWN:  w_expired = ((w_by11 + SPEED_11) > Y_LIMIT);
            DIR_LEFT:  w_expired = (w_bx11 < SPEED_11);
            DIR_RIGHT: w_expired = ((w_bx11 + SPEED_11) > X_LIMIT);
            default:   w_expired = 1'b1;
        endcase
    end

    // Frame-strobe edge detector: one Clk-wide tick per rising edge.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_frame_clk_d <= 1'b0;
            r_frame_tick  <= 1'b0;
        end else begin
            r_frame_clk_d <= bus.frame_clk;
            r_frame_tick  <= bus.frame_clk & ~r_frame_clk_d;
        end
    end

    // State register together with the registered outputs it governs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state      <= S_IDLE;
            r_bullet_x   <= 10'd0;
            r_bullet_y   <= 10'd0;
            r_bullet_dir <= 3'd0;
            r_active     <= 1'b0;
            r_fired      <= 1'b0;
            r_cnt        <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_bullet_x   <= w_bullet_x_nxt;
            r_bullet_y   <= w_bullet_y_nxt;
            r_bullet_dir <= w_bullet_dir_nxt;
            r_active     <= w_active_nxt;
            r_fired      <= w_fired_nxt;
            r_cnt        <= w_cnt_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_fire_ok) begin
                    w_state_nxt = S_FLIGHT;
                end
            end
            S_FLIGHT: begin
                // hit wins even when a frame tick lands on the same cycle
                if (bus.hit) begin
                    w_state_nxt = S_COOLDOWN;
                end else if (r_frame_tick && w_expired) begin
                    w_state_nxt = S_COOLDOWN;
                end
            end
            S_COOLDOWN: begin
                if (r_frame_tick && w_cnt_done) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output / datapath logic: next values of the registered outputs.
    always_comb begin
        w_bullet_x_nxt   = r_bullet_x;
        w_bullet_y_nxt   = r_bullet_y;
        w_bullet_dir_nxt = r_bullet_dir;
        w_active_nxt     = r_active;
        w_fired_nxt      = 1'b0;
        w_cnt_nxt        = r_cnt;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (w_fire_ok) begin
                    w_bullet_x_nxt   = bus.tank_X + SPAWN_OFS;
                    w_bullet_y_nxt   = bus.tank_Y + SPAWN_OFS;
                    w_bullet_dir_nxt = bus.tank_dir;
                    w_active_nxt     = 1'b1;
                    w_fired_nxt      = 1'b1;
                end
            end
            S_FLIGHT: begin
                // Holding the count at zero here means COOLDOWN always
                // starts counting from a clean zero.
                w_cnt_nxt = '0;
                if (bus.hit) begin
                    w_active_nxt = 1'b0;
                end else if (r_frame_tick) begin
                    if (w_expired) begin
                        w_active_nxt = 1'b0;
                    end else begin
                        case (r_bullet_dir)
                            DIR_UP:    w_bullet_y_nxt = r_bullet_y - SPEED_10;
                            DIR_DOWN:  w_bullet_y_nxt = r_bullet_y + SPEED_10;
                            DIR_LEFT:  w_bullet_x_nxt = r_bullet_x - SPEED_10;
                            DIR_RIGHT: w_bullet_x_nxt = r_bullet_x + SPEED_10;
                            default: begin
                                w_bullet_x_nxt = r_bullet_x;
                                w_bullet_y_nxt = r_bullet_y;
                            end
                        endcase
                    end
                end
            end
            S_COOLDOWN: begin
                w_active_nxt = 1'b0;
                if (r_frame_tick) begin
                    w_cnt_nxt = w_cnt_done ? '0 : r_cnt + 1'b1;
                end
            end
            default: begin
                w_active_nxt = 1'b0;
                w_cnt_nxt    = '0;
            end
        endcase
    end

    // Pixel hit-box: exactly BULLET_SIZE pixels per side from the top-left.
    assign bus.is_bullet = r_active &&
                           (w_dx11 >= w_bx11) && (w_dx11 <= w_bx11 + BOX_SPAN) &&
                           (w_dy11 >= w_by11) && (w_dy11 <= w_by11 + BOX_SPAN);

    assign bus.bullet_X      = r_bullet_x;
    assign bus.bullet_Y      = r_bullet_y;
    assign bus.bullet_dir    = r_bullet_dir;
    assign bus.bullet_active = r_active;
    assign bus.fired         = r_fired;
    assign bus.dbg_state     = r_state;

endmodule

// File: tb/tb_tank_bullet.sv
// ---------------------------------------------------------------------------
// tb_tank_bullet
// Directed, table-driven bench for tank_bullet. Inputs change on the falling
// clock edge and outputs are sampled on the falling edge, half a period
// after the rising edge that updated them.
// ---------------------------------------------------------------------------
module tb_tank_bullet;

    typedef struct {
        string      name;
        logic [9:0] dx;
        logic [9:0] dy;
        logic       exp;
    } pix_vec_t;

    typedef struct {
        string      name;
        logic [9:0] exp_x;
        logic       exp_active;
    } step_vec_t;

    logic Clk;
    logic Reset;
    int   n_checks;
    int   n_errors;
    int   fired_seen;
    int   fired_base;

    pix_vec_t  pix_tab[7];
    step_vec_t right_tab[6];
    logic [2:0] bad_dirs[4];

    tank_bullet_if bus();

    tank_bullet dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    always @(posedge Clk) begin
        if (bus.fired === 1'b1) fired_seen++;
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " bullet_X"},  32'(bus.bullet_X), 0);
        check({tag, " bullet_Y"},  32'(bus.bullet_Y), 0);
        check({tag, " dir"},       32'(bus.bullet_dir), 0);
        check({tag, " active"},    32'(bus.bullet_active), 0);
        check({tag, " fired"},     32'(bus.fired), 0);
        check({tag, " state"},     32'(bus.dbg_state), 0);
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    // Returns on the falling edge right after the rising edge on which the
    // design acted on the frame tick.
    task automatic frame_tick();
        @(negedge Clk);
        bus.frame_clk = 1'b1;
        @(negedge Clk);
        bus.frame_clk = 1'b0;
        @(negedge Clk);
    endtask

    // Pulses fire_req for one cycle; returns on the falling edge where fired
    // should be visible.
    task automatic spawn(input logic [9:0] x, input logic [9:0] y, input logic [2:0] dir);
        @(negedge Clk);
        bus.tank_X   = x;
        bus.tank_Y   = y;
        bus.tank_dir = dir;
        bus.fire_req = 1'b1;
        @(negedge Clk);
        bus.fire_req = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks   = 0;
        n_errors   = 0;
        fired_seen = 0;
        Reset      = 1'b1;
        bus.frame_clk = 1'b0;
        bus.fire_req  = 1'b0;
        bus.tank_X    = 10'd0;
        bus.tank_Y    = 10'd0;
        bus.tank_dir  = 3'd0;
        bus.hit       = 1'b0;
        bus.DrawX     = 10'd0;
        bus.DrawY     = 10'd0;

        pix_tab[0] = '{"pix top-left",     10'd114, 10'd390, 1'b1};
        pix_tab[1] = '{"pix bottom-right", 10'd117, 10'd393, 1'b1};
        pix_tab[2] = '{"pix right of box", 10'd118, 10'd390, 1'b0};
        pix_tab[3] = '{"pix below box",    10'd114, 10'd394, 1'b0};
        pix_tab[4] = '{"pix left of box",  10'd113, 10'd390, 1'b0};
        pix_tab[5] = '{"pix above box",    10'd114, 10'd389, 1'b0};
        pix_tab[6] = '{"pix top-right",    10'd117, 10'd390, 1'b1};

        right_tab[0] = '{"right tick1", 10'd618, 1'b1};
        right_tab[1] = '{"right tick2", 10'd622, 1'b1};
        right_tab[2] = '{"right tick3", 10'd626, 1'b1};
        right_tab[3] = '{"right tick4", 10'd630, 1'b1};
        right_tab[4] = '{"right tick5", 10'd634, 1'b1};
        right_tab[5] = '{"right tick6", 10'd634, 1'b0};

        bad_dirs[0] = 3'd0;
        bad_dirs[1] = 3'd5;
        bad_dirs[2] = 3'd6;
        bad_dirs[3] = 3'd7;

        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        check_reset_vals("reset");

        // invalid directions never spawn
        for (int i = 0; i < 4; i++) begin
            spawn(10'd100, 10'd100, bad_dirs[i]);
            check($sformatf("baddir%0d active", bad_dirs[i]), 32'(bus.bullet_active), 0);
            check($sformatf("baddir%0d fired", bad_dirs[i]), 32'(bus.fired), 0);
            check($sformatf("baddir%0d state", bad_dirs[i]), 32'(bus.dbg_state), 0);
        end

        // upward shot from (100,380)
        spawn(10'd100, 10'd380, 3'd1);
        check("up spawn fired",  32'(bus.fired), 1);
        check("up spawn active", 32'(bus.bullet_active), 1);
        check("up spawn X",      32'(bus.bullet_X), 114);
        check("up spawn Y",      32'(bus.bullet_Y), 394);
        check("up spawn dir",    32'(bus.bullet_dir), 1);
        check("up spawn state",  32'(bus.dbg_state), 1);
        @(negedge Clk);
        check("up fired one cycle", 32'(bus.fired), 0);
        fired_base = fired_seen;

        frame_tick();
        check("up tick1 Y", 32'(bus.bullet_Y), 390);
        check("up tick1 X", 32'(bus.bullet_X), 114);

        for (int i = 0; i < 7; i++) begin
            bus.DrawX = pix_tab[i].dx;
            bus.DrawY = pix_tab[i].dy;
            #1;
            check(pix_tab[i].name, 32'(bus.is_bullet), 32'(pix_tab[i].exp));
        end

        // tank movement and fire requests during flight are ignored
        bus.tank_X   = 10'd5;
        bus.tank_dir = 3'd2;
        bus.fire_req = 1'b1;
        repeat (97) frame_tick();
        check("up tick98 Y",      32'(bus.bullet_Y), 2);
        check("up tick98 X",      32'(bus.bullet_X), 114);
        check("up tick98 active", 32'(bus.bullet_active), 1);
        check("up tick98 dir",    32'(bus.bullet_dir), 1);
        frame_tick();
        check("up retire active", 32'(bus.bullet_active), 0);
        check("up retire Y",      32'(bus.bullet_Y), 2);
        check("up retire state",  32'(bus.dbg_state), 2);
        check("no fire in flight", 32'(fired_seen), 32'(fired_base));

        bus.DrawX = 10'd114;
        bus.DrawY = 10'd2;
        #1;
        check("pix inactive", 32'(bus.is_bullet), 0);

        // fire_req held through the whole cooldown
        bus.tank_X   = 10'd100;
        bus.tank_Y   = 10'd380;
        bus.tank_dir = 3'd1;
        repeat (29) frame_tick();
        check("cool29 state", 32'(bus.dbg_state), 2);
        check("cool29 no fire", 32'(fired_seen), 32'(fired_base));
        frame_tick();
        check("cool30 state idle", 32'(bus.dbg_state), 0);
        check("cool30 fired low",  32'(bus.fired), 0);
        @(negedge Clk);
        bus.fire_req = 1'b0;
        check("refire fired",  32'(bus.fired), 1);
        check("refire state",  32'(bus.dbg_state), 1);
        check("refire active", 32'(bus.bullet_active), 1);
        check("refire Y",      32'(bus.bullet_Y), 394);

        // hit coinciding with a frame tick: no move, retire
        @(negedge Clk);
        bus.frame_clk = 1'b1;
        @(negedge Clk);
        bus.frame_clk = 1'b0;
        bus.hit       = 1'b1;
        @(negedge Clk);
        bus.hit = 1'b0;
        check("hit active", 32'(bus.bullet_active), 0);
        check("hit Y held", 32'(bus.bullet_Y), 394);
        check("hit X held", 32'(bus.bullet_X), 114);
        check("hit state",  32'(bus.dbg_state), 2);

        do_reset();
        check_reset_vals("reset2");

        // rightward shot toward the right edge
        spawn(10'd600, 10'd200, 3'd2);
        check("right spawn fired", 32'(bus.fired), 1);
        check("right spawn X",     32'(bus.bullet_X), 614);
        check("right spawn Y",     32'(bus.bullet_Y), 214);
        bus.tank_X   = 10'd0;
        bus.tank_dir = 3'd1;
        for (int i = 0; i < 6; i++) begin
            frame_tick();
            check({right_tab[i].name, " X"}, 32'(bus.bullet_X), 32'(right_tab[i].exp_x));
            check({right_tab[i].name, " active"}, 32'(bus.bullet_active),
                  32'(right_tab[i].exp_active));
        end
        check("right retire state", 32'(bus.dbg_state), 2);

        // reset in the middle of a flight
        do_reset();
        spawn(10'd300, 10'd300, 3'd4);
        check("down spawn active", 32'(bus.bullet_active), 1);
        frame_tick();
        check("down tick1 Y", 32'(bus.bullet_Y), 318);
        fired_base = fired_seen;
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        check_reset_vals("midflight reset");
        @(negedge Clk);
        check("midflight no pulse", 32'(fired_seen), 32'(fired_base));
        check("midflight stays idle", 32'(bus.bullet_active), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/tank_bullet.md
Name: tank_bullet

Overview:
- Projectile controller directly downstream of the AI/player tank movers.
- Consumes the tank's position, direction and a fire request, and spawns one bullet.
- Advances the bullet once per frame along the tank direction, retires it on a screen edge or an external hit, then enforces a reload cooldown.
- Provides bullet coordinates to the collision logic and a per-pixel is_bullet flag to the colour mapper.

Parameters:
- X_MAX, 639, rightmost screen column
- Y_MAX, 479, bottom screen row
- TANK_SIZE, 32, tank sprite edge in pixels
- BULLET_SIZE, 4, bullet square edge in pixels
- SPEED, 4, pixels moved per frame tick
- COOLDOWN_FRAMES, 30, frame ticks between bullet retirement and re-arm; minimum 1

Ports:
- Clk  in  1  system clock, 50 MHz
- Reset  in  1  synchronous, active-high
- frame_clk  in  1  ~60 Hz frame strobe, asynchronous level
- fire_req  in  1  level request to fire
- tank_X  in  10  tank top-left X
- tank_Y  in  10  tank top-left Y
- tank_dir  in  3  1=up, 2=right, 3=left, 4=down; other codes are invalid
- hit  in  1  external collision; retires the bullet
- DrawX, DrawY  in  10 each  current VGA pixel
- bullet_X, bullet_Y  out  10 each  bullet top-left position
- bullet_dir  out  3  latched direction
- bullet_active  out  1  bullet in flight
- fired  out  1  one-cycle pulse on spawn
- is_bullet  out  1  current pixel is inside the bullet

Behaviour:
- Reset is synchronous and active-high. The clock is Clk.
- Reset values:
  - state IDLE
  - bullet_X, bullet_Y = 0
  - bullet_dir = 0
  - bullet_active = 0
  - fired = 0
  - cooldown count = 0
  - frame edge registers = 0
- Reset mid-flight kills the bullet immediately. No pulse is emitted.
- Frame tick:
  - frame_clk is registered into frame_clk_d every cycle.
  - frame_tick is registered as (frame_clk & ~frame_clk_d).
  - frame_tick is high for exactly one Clk cycle per rising edge of frame_clk.
- State IDLE:
  - Condition: fire_req=1 and tank_dir is in {1,2,3,4}.
  - On the next cycle the state becomes FLIGHT and fired=1 for that cycle.
  - bullet_X = tank_X + (TANK_SIZE-BULLET_SIZE)/2.
  - bullet_Y = tank_Y + (TANK_SIZE-BULLET_SIZE)/2.
  - bullet_dir = tank_dir. bullet_active = 1.
  - An invalid tank_dir leaves the block in IDLE.
  - fire_req is a level, not an edge. Holding it high re-fires as soon as the block re-arms.
- State FLIGHT:
  - hit=1 has priority over everything else: go to COOLDOWN next cycle, bullet_active=0, position held.
  - This applies even if frame_tick coincides.
  - Otherwise, on frame_tick, check expiry (compare in 11 bits, no 10-bit wrap):
    - up: bullet_Y < SPEED
    - down: bullet_Y + SPEED > Y_MAX+1-BULLET_SIZE
    - left: bullet_X < SPEED
    - right: bullet_X + SPEED > X_MAX+1-BULLET_SIZE
  - Expired: go to COOLDOWN, bullet_active=0, position held.
  - Not expired: move by SPEED in bullet_dir.
  - tank_X, tank_Y and tank_dir changes during flight have no effect.
  - fire_req is ignored and is not queued.
- State COOLDOWN:
  - The count clears to 0 on entry.
  - Each frame_tick increments the count.
  - On a frame_tick with count == COOLDOWN_FRAMES-1, go to IDLE.
  - fire_req and hit are ignored.
- is_bullet (combinational):
  - is_bullet = bullet_active & (bullet_X <= DrawX <= bullet_X+BULLET_SIZE-1) & (bullet_Y <= DrawY <= bullet_Y+BULLET_SIZE-1).
  - The box is exactly BULLET_SIZE pixels per side.
- Latency:
  - fire_req to fired/bullet_active: 1 cycle.
  - A position update appears the cycle after frame_tick.

Test Plan:
- Reset, then tank (100,380) dir=1, pulse fire_req → next cycle fired=1 for 1 cycle, bullet (114,394), active=1. After 1 tick Y=390. After 98 ticks Y=2. The 99th tick retires the bullet: active=0, Y stays 2.
- Tank (600,200) dir=2, fire → X = 614, 618, 622, 626, 630, 634 over 5 ticks. The 6th tick retires with X=634.
- In FLIGHT assert hit on the same cycle as frame_tick → no move, active=0 next cycle, state COOLDOWN.
- Hold fire_req high continuously after a retirement → no fired pulse for 29 ticks; fired is asserted the cycle after the 30th tick brings the block to IDLE.
- fire_req with tank_dir=0 or 5 → no spawn, active stays 0. Assert Reset mid-flight → all outputs at reset values next cycle.
- Bullet at (114,390): DrawX/DrawY=(114,390) and (117,393) → is_bullet=1. (118,390) and (114,394) → 0. Inactive bullet → 0 everywhere.
